// File: rtl/apuracao_votos.sv
// Sequential vote tally: accumulates popcount-based yes/no totals over a session
// through a two-stage pipeline and publishes registered, saturating results on close.
module apuracao_votos #(
    parameter int N_VOTERS = 3,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N_VOTERS-1:0] V,
    input  logic                V_valid,
    input  logic                close,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    SIM,
    output logic [CNT_W-1:0]    NAO,
    output logic [CNT_W-1:0]    RODADAS,
    output logic                aprovado,
    output logic                empate,
    output logic                sat
);

    localparam int PW = $clog2(N_VOTERS + 1);
    localparam logic [PW-1:0] N_P = PW'(N_VOTERS);

    typedef enum logic [1:0] {IDLE, OPEN, DRAIN, DONE} state_t;

    state_t          state;
    logic            drain_wait;
    logic            vld_p1;
    logic [PW-1:0]   p_p1;
    logic [PW-1:0]   q_p1;
    logic [CNT_W:0]  sim_s, nao_s, rod_s;

    function automatic logic [PW-1:0] popcount(input logic [N_VOTERS-1:0] v);
        logic [PW-1:0] c;
        c = '0;
        for (int i = 0; i < N_VOTERS; i++) c = c + PW'(v[i]);
        return c;
    endfunction

    // Returns {overflow, result}; an overflowing sum is clamped to the counter maximum.
    function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[CNT_W]) s = {1'b1, {CNT_W{1'b1}}};
        return s;
    endfunction

    always_comb begin
        sim_s = sat_add(SIM, CNT_W'(p_p1));
        nao_s = sat_add(NAO, CNT_W'(q_p1));
        rod_s = sat_add(RODADAS, CNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            drain_wait <= 1'b0;
            vld_p1     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            SIM        <= '0;
            NAO        <= '0;
            RODADAS    <= '0;
            aprovado   <= 1'b0;
            empate     <= 1'b0;
            sat        <= 1'b0;
        end else begin
            // stage 2: accumulate the round registered in stage 1
            if (vld_p1) begin
                SIM     <= sim_s[CNT_W-1:0];
                NAO     <= nao_s[CNT_W-1:0];
                RODADAS <= rod_s[CNT_W-1:0];
                sat     <= sat | sim_s[CNT_W] | nao_s[CNT_W] | rod_s[CNT_W];
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= OPEN;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        vld_p1   <= 1'b0;
                        p_p1     <= '0;
                        q_p1     <= '0;
                        SIM      <= '0;
                        NAO      <= '0;
                        RODADAS  <= '0;
                        aprovado <= 1'b0;
                        empate   <= 1'b0;
                        sat      <= 1'b0;
                    end
                end
                OPEN: begin
                    // stage 1: register the round's yes/no split
                    vld_p1 <= V_valid;
                    if (V_valid) begin
                        p_p1 <= popcount(V);
                        q_p1 <= N_P - popcount(V);
                    end
                    if (close) begin
                        state      <= DRAIN;
                        drain_wait <= 1'b0;
                    end
                end
                DRAIN: begin
                    vld_p1 <= 1'b0;
                    // first cycle lets the last round land; flags then see final totals
                    if (!drain_wait) begin
                        drain_wait <= 1'b1;
                    end else begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        aprovado <= (SIM > NAO);
                        empate   <= (SIM == NAO);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/apuracao_votos.md
# apuracao_votos

Sequential, parametrised vote-tally unit that succeeds the combinational three-voter counter. Over an open session it accumulates yes/no votes from `N_VOTERS` parallel ballot lines, one ballot round per valid cycle. On close it publishes registered totals plus approved/tie/saturation flags, and holds them until the next session starts. It sits between the ballot-input front end and the result display/decoder.

## Interface
- `N_VOTERS`, default 3: number of voter lines per ballot round (≥1).
- `CNT_W`, default 8: width of the yes, no and round counters (≥ $clog2(N_VOTERS+1)).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: open a new session; honoured only in IDLE or DONE.
- `V` in N_VOTERS: ballot round; bit i = 1 means voter i votes yes, 0 means no.
- `V_valid` in 1: `V` carries a round this cycle; honoured only in OPEN.
- `close` in 1: end the session; honoured only in OPEN.
- `busy` out 1: state is OPEN or DRAIN.
- `done` out 1: state is DONE; results are stable.
- `SIM` out CNT_W: yes-vote total.
- `NAO` out CNT_W: no-vote total.
- `RODADAS` out CNT_W: number of accepted rounds.
- `aprovado` out 1: SIM > NAO. Valid only while `done`, 0 otherwise.
- `empate` out 1: SIM == NAO. Valid only while `done`, 0 otherwise.
- `sat` out 1: sticky; some counter saturated during this session.

## Operation
- FSM states: IDLE, OPEN, DRAIN, DONE.
- IDLE:
  - `start` → OPEN.
- OPEN:
  - `close` → DRAIN.
  - `start` is ignored.
- DRAIN: unconditional → DONE after one cycle.
- DONE:
  - `start` → OPEN.
  - `V_valid` and `close` are ignored.
- Any state, `rst` → IDLE. `rst` overrides all inputs, including mid-session.
- Session start (edge where `start` is honoured):
  - SIM, NAO, RODADAS, `sat`, `aprovado`, `empate` and the pipeline register clear to 0.
- Pipeline stage 1, in OPEN with `V_valid`=1:
  - Register p = popcount(V), width $clog2(N_VOTERS+1).
  - Register q = N_VOTERS − p.
  - Set the stage-1 valid bit.
  - `V_valid` in the same cycle as `close` is accepted.
- Stage 2, when the stage-1 valid bit is set:
  - SIM += p, NAO += q, RODADAS += 1.
- Arithmetic is unsigned.
  - Each counter saturates at 2^CNT_W−1 and never wraps.
  - If any add would exceed the maximum, that counter holds the maximum and `sat` sets to 1.
  - `sat` stays 1 until a new start or reset.
- On entry to DONE:
  - `aprovado` = (SIM > NAO) and `empate` = (SIM == NAO), both computed from the final counters and registered.
  - Both are held until leaving DONE.
- A session with zero rounds ends with SIM = NAO = RODADAS = 0 and `empate`=1.
- `V` is ignored whenever `V_valid`=0 or the state is not OPEN.

## Timing
- Reset values: `busy`=0, `done`=0, SIM=NAO=RODADAS=0, `aprovado`=0, `empate`=0, `sat`=0, state IDLE, stage-1 valid bit 0.
- `start` sampled at edge k: `busy`=1 and counters are 0 after edge k.
- Round latency: a round sampled at edge t is reflected in SIM/NAO/RODADAS after edge t+1.
- Throughput: one round per cycle, back-to-back `V_valid` supported.
- `close` sampled at edge c:
  - DRAIN after edge c; the last round (t ≤ c) accumulates at edge c+1.
  - DONE after edge c+2 with `done`=1 and flags valid, so `done` rises 2 cycles after `close`.
- `start` sampled in DONE at edge d:
  - `done`=0, `busy`=1 and everything cleared after edge d.
- `start` and `close` asserted together in OPEN: `close` wins, `start` is ignored.
- `rst` asserted while a round is in stage 1: the round is discarded and never counted.

## Test plan
- Use N_VOTERS=3, CNT_W=4 unless noted.
- Basic tally:
  - Stimulus: `start`; rounds V=111, 011, 000 on consecutive cycles; `close` with the last round.
  - Response: `done` 2 cycles after `close`; SIM=5, NAO=4, RODADAS=3, `aprovado`=1, `empate`=0, `sat`=0.
- Tie:
  - Stimulus: rounds V=011, 100, then `close`.
  - Response: SIM=3, NAO=3, RODADAS=2, `empate`=1, `aprovado`=0.
- Saturation:
  - Stimulus: 6 rounds of V=111, then `close`.
  - Response: SIM=15 (held, not 2), NAO=0, RODADAS=6, `sat`=1, `aprovado`=1.
- Empty session and ignored inputs:
  - Stimulus: `start`; `close` with no rounds; then `V_valid`=1 with V=111 while in DONE.
  - Response: SIM=NAO=RODADAS=0, `empate`=1; counters unchanged by the DONE-state rounds.
- Reset mid-session:
  - Stimulus: after 2 rounds of V=111, assert `rst` in the same cycle as a third round.
  - Response: next cycle all outputs 0, state IDLE; a subsequent session counts from 0 and gives correct totals.
- Restart from DONE plus parameter sweep:
  - Stimulus: `start` while `done`=1.
  - Response: all results clear next cycle, `busy`=1.
  - Repeat the basic tally with N_VOTERS=8, CNT_W=8: V=FF, 0F gives SIM=12, NAO=4.
